// File: rtl/boron_pkg.sv
// Boron-64 shared definitions: S-box, rotation amounts, FSM states.
// Imported by the encryption core and its datapath helpers.
package boron_pkg;

  localparam int ROUNDS_DEFAULT = 25;
  localparam int ROT_W0 = 1;
  localparam int ROT_W1 = 4;
  localparam int ROT_W2 = 7;
  localparam int ROT_W3 = 9;
  localparam int KEY_ROT = 13;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  function automatic logic [15:0] rotl16(
    input logic [15:0] w,
    input int unsigned n
  );
    return (w << n) | (w >> (16 - n));
  endfunction

endpackage

// File: rtl/block_shuffle_encryption.sv
// Boron block shuffle: swaps the two bytes of every 16-bit word.
// Purely combinational, 64 bits in and out.
module block_shuffle_encryption (
  input  logic [63:0] d_i,
  output logic [63:0] d_o
);

  for (genvar i = 0; i < 4; i++) begin : g_word
    assign d_o[16*i +: 16] = {d_i[16*i +: 8], d_i[16*i+8 +: 8]};
  end

endmodule

// File: rtl/boron_encrypt_core.sv
// Iterative Boron-64 encryption core, one round per clock.
// Valid/ready on both sides, one block in flight at a time.
module boron_encrypt_core
  import boron_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] data_i,
  input  logic [79:0] key_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] data_o
);

  localparam logic [4:0] RC_LAST = 5'(ROUNDS);

  state_e      state_q, state_d;
  logic [63:0] s_q, s_d;
  logic [79:0] k_q, k_d;
  logic [4:0]  rc_q, rc_d;
  logic        valid_q, valid_d;
  logic [63:0] data_q, data_d;

  logic [63:0] x;
  logic [63:0] sb;
  logic [63:0] sh;
  logic [63:0] round_out;
  logic [79:0] k_rot;
  logic [79:0] k_nxt;
  logic [15:0] w0, w1, w2, w3;

  always_comb begin
    x = s_q ^ k_q[63:0];
    sb = '0;
    for (int i = 0; i < 16; i++) begin
      sb[4*i +: 4] = sbox(x[4*i +: 4]);
    end
  end

  block_shuffle_encryption u_shuffle (
    .d_i (sb),
    .d_o (sh)
  );

  // Each XOR uses the word updated just before it.
  always_comb begin
    w0 = rotl16(sh[15:0],  ROT_W0);
    w1 = rotl16(sh[31:16], ROT_W1);
    w2 = rotl16(sh[47:32], ROT_W2);
    w3 = rotl16(sh[63:48], ROT_W3);
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    w0 = w0 ^ w3;
    round_out = {w3, w2, w1, w0};
  end

  always_comb begin
    k_rot = (k_q << KEY_ROT) | (k_q >> (80 - KEY_ROT));
    k_nxt = k_rot;
    k_nxt[3:0] = sbox(k_rot[3:0]);
    k_nxt[63:59] = k_rot[63:59] ^ rc_q;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rc_d    = rc_q;
    valid_d = valid_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          s_d     = data_i;
          k_d     = key_i;
          rc_d    = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rc_q == RC_LAST) begin
          data_d  = round_out ^ k_nxt[63:0];
          valid_d = 1'b1;
          rc_d    = 5'd0;
          state_d = DONE;
        end else begin
          s_d  = round_out;
          k_d  = k_nxt;
          rc_d = rc_q + 5'd1;
        end
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rc_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rc_q    <= rc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
